// File: rtl/multiplier_pkg.sv
// Shared definitions for the shift-add multiply-accumulate pipeline.
// MUL_W matches the divider so quotient/divisor/remainder feed straight in.
package multiplier_pkg;

  localparam int MUL_W = 8;

endpackage

// File: rtl/multiplier_stage.sv
// One pipeline stage: adds A<<IDX into the running sum when bit IDX of B is set,
// then registers sum, operand copies and valid. ihold freezes every register.
module multiplier_stage
  import multiplier_pkg::*;
#(
  parameter int W   = MUL_W,
  parameter int IDX = 0
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             ihold,
  input  logic             ivalid,
  input  logic [W-1:0]     ia,
  input  logic [W-1:0]     ib,
  input  logic [2*W-1:0]   iacc,
  output logic             ovalid,
  output logic [W-1:0]     oa,
  output logic [W-1:0]     ob,
  output logic [2*W-1:0]   oacc
);

  logic             valid_d, valid_q;
  logic [W-1:0]     a_d, a_q;
  logic [W-1:0]     b_d, b_q;
  logic [2*W-1:0]   acc_d, acc_q;
  logic [2*W-1:0]   pp_s;

  // Partial product select and next-state with hold
  always_comb begin
    pp_s    = {(2*W){1'b0}};
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    if (ib[IDX]) begin
      pp_s = {{W{1'b0}}, ia} << IDX;
    end else begin
      pp_s = {(2*W){1'b0}};
    end
    // The full product never exceeds 2*W bits, so no carry out is kept.
    if (ihold) begin
      valid_d = valid_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
    end else begin
      valid_d = ivalid;
      a_d     = ia;
      b_d     = ib;
      acc_d   = iacc + pp_s;
    end
  end

  // Stage registers
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      valid_q <= 1'b0;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      acc_q   <= {(2*W){1'b0}};
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign ovalid = valid_q;
  assign oa     = a_q;
  assign ob     = b_q;
  assign oacc   = acc_q;

endmodule

// File: rtl/multiplier.sv
// Pipelined unsigned multiply-accumulate: oproduct = imultiplicand*imultiplier + iaddend.
// W stages, one per multiplier bit; result and valid appear W edges after sampling.
module multiplier
  import multiplier_pkg::*;
#(
  parameter int W = MUL_W
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             ivalid,
  input  logic             ihold,
  input  logic [W-1:0]     imultiplicand,
  input  logic [W-1:0]     imultiplier,
  input  logic [W-1:0]     iaddend,
  output logic             ovalid,
  output logic [2*W-1:0]   oproduct
);

  logic [W:0]              valid_s;
  logic [W:0][W-1:0]       a_s;
  logic [W:0][W-1:0]       b_s;
  logic [W:0][2*W-1:0]     acc_s;
  logic [2*W-1:0]          unused_ab_s;

  assign valid_s[0] = ivalid;
  assign a_s[0]     = imultiplicand;
  assign b_s[0]     = imultiplier;
  assign acc_s[0]   = {{W{1'b0}}, iaddend};

  for (genvar i = 0; i < W; i++) begin : g_stage
    multiplier_stage #(
      .W   (W),
      .IDX (i)
    ) u_stage (
      .iclk   (iclk),
      .irst_n (irst_n),
      .ihold  (ihold),
      .ivalid (valid_s[i]),
      .ia     (a_s[i]),
      .ib     (b_s[i]),
      .iacc   (acc_s[i]),
      .ovalid (valid_s[i+1]),
      .oa     (a_s[i+1]),
      .ob     (b_s[i+1]),
      .oacc   (acc_s[i+1])
    );
  end

  // The last stage's operand copies have no consumer.
  assign unused_ab_s = {a_s[W], b_s[W]};

  assign ovalid   = valid_s[W];
  assign oproduct = acc_s[W];

endmodule

// File: tb/tb_multiplier.sv
// Bench for multiplier: vector table plus scoreboard keyed on expected output edge.
module tb_multiplier;

  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ivalid;
  logic             ihold;
  logic [W-1:0]     a, b, c;
  logic             ovalid;
  logic [2*W-1:0]   oproduct;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2*W-1:0] exp;
    int             due;
    int             hold0;
  } sb_t;
  sb_t q[$];

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   c;
    logic [2*W-1:0] exp;
  } vec_t;
  vec_t vecs[5];

  int   edge_cnt = 0;
  int   hold_cnt = 0;
  logic adv = 1'b0;

  logic             fv;
  logic [2*W-1:0]   fp;
  logic [W-1:0]     ra, rb, rc;
  int unsigned      dvd, dsr, quo, rem;

  always #5 clk = ~clk;

  multiplier #(.W(W)) dut (
    .iclk          (clk),
    .irst_n        (rst_n),
    .ivalid        (ivalid),
    .ihold         (ihold),
    .imultiplicand (a),
    .imultiplier   (b),
    .iaddend       (c),
    .ovalid        (ovalid),
    .oproduct      (oproduct)
  );

  // Edge and hold bookkeeping for expected output timing
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (ihold && rst_n) hold_cnt <= hold_cnt + 1;
    adv <= rst_n && !ihold;
  end

  // Scoreboard: each result must appear exactly on its due edge, in order
  always @(negedge clk) begin
    sb_t e;
    if (rst_n === 1'b1 && adv) begin
      if (ovalid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ovalid: got oproduct=%0d at edge %0d, required no ovalid", oproduct, edge_cnt);
        end else begin
          e = q.pop_front();
          if (oproduct !== e.exp || edge_cnt != e.due + hold_cnt - e.hold0) begin
            errors++;
            $display("FAIL scoreboard: got %0d at edge %0d, required %0d at edge %0d",
                     oproduct, edge_cnt, e.exp, e.due + hold_cnt - e.hold0);
          end
        end
      end else if (q.size() != 0 && edge_cnt >= q[0].due + hold_cnt - q[0].hold0) begin
        checks++;
        errors++;
        e = q.pop_front();
        $display("FAIL missing_ovalid: got ovalid=%b at edge %0d, required result %0d", ovalid, edge_cnt, e.exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic h, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic [W-1:0] tc, input logic [2*W-1:0] texp);
    ivalid = v;
    ihold  = h;
    a      = ta;
    b      = tb_;
    c      = tc;
    if (v && !h && rst_n) q.push_back('{texp, edge_cnt + W, hold_cnt});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 16'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    ivalid = 1'b0;
    ihold  = 1'b0;
    a = 8'd0; b = 8'd0; c = 8'd0;
    vecs[0] = '{8'd13,  8'd11,  8'd7,   16'd150};
    vecs[1] = '{8'd255, 8'd255, 8'd255, 16'd65280};
    vecs[2] = '{8'd0,   8'd200, 8'd9,   16'd9};
    vecs[3] = '{8'd1,   8'd1,   8'd0,   16'd1};
    vecs[4] = '{8'd128, 8'd2,   8'd255, 16'd511};

    // Reset held over three edges with valid operands present
    ivalid = 1'b1; a = 8'd200; b = 8'd99; c = 8'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_ovalid", {31'd0, ovalid}, 32'd0);
      chk("reset_oproduct", {16'd0, oproduct}, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      chk("post_reset_idle", {31'd0, ovalid}, 32'd0);
    end

    // Single operation: ovalid on exactly the 8th edge
    cycle(1'b1, 1'b0, vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].exp);
    for (int i = 2; i <= 9; i++) begin
      idle(1);
      chk("single_latency", {31'd0, ovalid}, (i == 8) ? 32'd1 : 32'd0);
      if (i == 8) chk("single_value", {16'd0, oproduct}, 32'd150);
    end

    // Extremes back-to-back
    for (int k = 1; k < 5; k++) cycle(1'b1, 1'b0, vecs[k].a, vecs[k].b, vecs[k].c, vecs[k].exp);
    idle(W + 2);

    // Hold mid-stream: 8 ops, 3 held cycles with dropped inputs, 2 more ops
    for (int k = 0; k < 13; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 8'($urandom_range(0, 255));
      if (k >= 8 && k <= 10) begin
        if (k == 8) begin
          fv = ovalid;
          fp = oproduct;
          chk("hold_out_valid", {31'd0, fv}, 32'd1);
        end
        cycle(1'b1, 1'b1, ra, rb, rc, 16'd0);
        chk("hold_frozen_valid", {31'd0, ovalid}, {31'd0, fv});
        chk("hold_frozen_product", {16'd0, oproduct}, {16'd0, fp});
      end else begin
        cycle(1'b1, 1'b0, ra, rb, rc, 16'(ra) * 16'(rb) + 16'(rc));
      end
    end
    idle(W + 4);

    // Reset mid-flight: asynchronous assertion between edges
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 8'(50 + k), 8'd77, 8'd3, 16'(50 + k) * 16'd77 + 16'd3);
    ivalid = 1'b1; a = 8'd60; b = 8'd61; c = 8'd62;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_ovalid", {31'd0, ovalid}, 32'd0);
    chk("midreset_oproduct", {16'd0, oproduct}, 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b0, 8'd70, 8'd71, 8'd72, 16'd0);
    cycle(1'b1, 1'b0, 8'd80, 8'd81, 8'd82, 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      chk("midreset_no_stale", {31'd0, ovalid}, 32'd0);
    end

    // Round trip from divider outputs, with occasional dropped-on-hold cycles
    for (int n = 0; n < 1000; n++) begin
      dsr = $urandom_range(1, 255);
      dvd = $urandom_range(0, 256 * dsr - 1);
      quo = dvd / dsr;
      rem = dvd - quo * dsr;
      if ($urandom_range(0, 15) == 0)
        cycle(1'b1, 1'b1, 8'($urandom_range(0, 255)), 8'd3, 8'd4, 16'd0);
      cycle(1'b1, 1'b0, 8'(quo), 8'(dsr), 8'(rem), 16'(dvd));
    end
    idle(W + 4);
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
